// File: rtl/layer_accumulator_pkg.sv
// rtl/layer_accumulator_pkg.sv - shared constants and FSM encoding for the layer accumulator and ReLU stage
package layer_accumulator_pkg;

    localparam int N_NEURONS = 32;
    localparam int DATA_W    = 8;
    localparam int ACC_W     = 20;
    localparam int BIAS_W    = 16;
    localparam int PROD_W    = 2 * DATA_W;
    localparam int CNT_W     = 10;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]        CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } acc_state_e;

endpackage

// File: rtl/layer_accumulator_mac_lane.sv
// rtl/layer_accumulator_mac_lane.sv - one neuron lane: signed multiply, widened add, saturate to accumulator width
module mac_lane
    import layer_accumulator_pkg::*;
(
    input  logic signed [ACC_W-1:0]  acc_i,
    input  logic signed [DATA_W-1:0] x_i,
    input  logic signed [DATA_W-1:0] w_i,
    output logic signed [ACC_W-1:0]  sum_o
);

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W:0]    sum_wide;

    // Sum is formed one bit wider than the accumulator so overflow shows as a top-two-bit disagreement
    always_comb begin
        prod     = x_i * w_i;
        sum_wide = {acc_i[ACC_W-1], acc_i} + {{(ACC_W+1-PROD_W){prod[PROD_W-1]}}, prod};
        if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
            sum_o = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            sum_o = sum_wide[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/layer_accumulator.sv
// rtl/layer_accumulator.sv - N-lane bias-preloaded MAC accumulator producing one pre-activation vector per pass
module layer_accumulator
    import layer_accumulator_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [CNT_W-1:0]              num_inputs,
    input  logic [N_NEURONS*BIAS_W-1:0]   bias_packed,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             x_in,
    input  logic [N_NEURONS*DATA_W-1:0]   w_in_packed,
    output logic [N_NEURONS*ACC_W-1:0]    z_out_packed,
    output logic                          z_valid,
    input  logic                          z_ready,
    output logic                          busy
);

    acc_state_e                        state_q, state_d;
    logic [CNT_W-1:0]                  cnt_q, cnt_d;
    logic [CNT_W-1:0]                  k_q, k_d;
    logic [N_NEURONS-1:0][ACC_W-1:0]   acc_q, acc_d;
    logic [N_NEURONS-1:0][ACC_W-1:0]   mac_sum;

    // One MAC lane per neuron, all sharing the broadcast activation
    for (genvar g = 0; g < N_NEURONS; g++) begin : g_lane
        mac_lane u_mac (
            .acc_i (acc_q[g]),
            .x_i   (x_in),
            .w_i   (w_in_packed[g*DATA_W +: DATA_W]),
            .sum_o (mac_sum[g])
        );
    end

    // Next-state, counter and accumulator update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        acc_d   = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    k_d   = num_inputs;
                    cnt_d = '0;
                    for (int j = 0; j < N_NEURONS; j++) begin
                        acc_d[j] = {{(ACC_W-BIAS_W){bias_packed[j*BIAS_W+BIAS_W-1]}},
                                    bias_packed[j*BIAS_W +: BIAS_W]};
                    end
                    state_d = (num_inputs == '0) ? ST_DONE : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (in_valid) begin
                    acc_d = mac_sum;
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == k_q - CNT_ONE) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (z_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any partial pass
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            k_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
        end
    end

    assign in_ready     = (state_q == ST_ACCUM);
    assign z_valid      = (state_q == ST_DONE);
    assign busy         = (state_q != ST_IDLE);
    assign z_out_packed = acc_q;

endmodule

// File: tb/tb_layer_accumulator.sv
// tb/tb_layer_accumulator.sv - directed table-driven bench for layer_accumulator
module tb_layer_accumulator;
    import layer_accumulator_pkg::*;

    logic                          clk = 1'b0;
    logic                          rst_n = 1'b1;
    logic                          start = 1'b0;
    logic [CNT_W-1:0]              num_inputs = '0;
    logic [N_NEURONS*BIAS_W-1:0]   bias_packed = '0;
    logic                          in_valid = 1'b0;
    logic                          in_ready;
    logic [DATA_W-1:0]             x_in = '0;
    logic [N_NEURONS*DATA_W-1:0]   w_in_packed = '0;
    logic [N_NEURONS*ACC_W-1:0]    z_out_packed;
    logic                          z_valid;
    logic                          z_ready = 1'b0;
    logic                          busy;

    int tests = 0;
    int fails = 0;

    layer_accumulator dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .num_inputs   (num_inputs),
        .bias_packed  (bias_packed),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .x_in         (x_in),
        .w_in_packed  (w_in_packed),
        .z_out_packed (z_out_packed),
        .z_valid      (z_valid),
        .z_ready      (z_ready),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    k;
        int    x0;
        int    xstep;
        int    w;
        int    bias;
        int    gap;
        int    exp_z;
        string name;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic signed [31:0] lane_val(input int j);
        logic signed [ACC_W-1:0] v;
        v = z_out_packed[j*ACC_W +: ACC_W];
        return 32'(v);
    endfunction

    task automatic chk_lanes(input string nm, input int exp);
        int bad;
        bad = 0;
        for (int j = N_NEURONS-1; j >= 0; j--) begin
            if (lane_val(j) !== exp) bad = j;
        end
        chk($sformatf("%s lane%0d", nm, bad), lane_val(bad), exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_pass(input vec_t v);
        int bad_rdy;
        int xv;
        int wv;
        int bv;
        bad_rdy = 0;
        bv = v.bias;
        wv = v.w;
        start = 1'b1;
        num_inputs = v.k[CNT_W-1:0];
        bias_packed = {N_NEURONS{bv[BIAS_W-1:0]}};
        tick();
        start = 1'b0;
        for (int i = 0; i < v.k; i++) begin
            if (in_ready !== 1'b1 || z_valid !== 1'b0) bad_rdy++;
            xv = v.x0 + i * v.xstep;
            in_valid = 1'b1;
            x_in = xv[DATA_W-1:0];
            w_in_packed = {N_NEURONS{wv[DATA_W-1:0]}};
            tick();
            in_valid = 1'b0;
            if (v.gap != 0 && i != v.k - 1) begin
                if (in_ready !== 1'b1 || z_valid !== 1'b0) bad_rdy++;
                tick();
            end
        end
        chk({v.name, " accum_cycles_bad"}, bad_rdy, 0);
        chk({v.name, " z_valid_latency"}, 32'(z_valid), 1);
        chk_lanes(v.name, v.exp_z);
        z_ready = 1'b1;
        tick();
        z_ready = 1'b0;
        chk({v.name, " released"}, 32'({z_valid, busy, in_ready}), 0);
    endtask

    initial begin
        int bad;
        logic [N_NEURONS*ACC_W-1:0] held;
        logic [BIAS_W-1:0] bm100;
        vec_t r;

        vecs[0] = '{3,    1,   1,    1,   0,     0, 6,       "k3_ramp"};
        vecs[1] = '{40,   127, 0,    127, 0,     0, 524287,  "sat_pos"};
        vecs[2] = '{40,   127, 0,    -128, 0,    0, -524288, "sat_neg"};
        vecs[3] = '{4,    1,   1,    1,   0,     1, 10,      "gap4"};
        vecs[4] = '{4,    1,   1,    1,   0,     0, 10,      "b2b4"};
        vecs[5] = '{2,    -3,  0,    5,   100,   0, 70,      "bias_neg_prod"};
        vecs[6] = '{1,    -128, 0,   -128, -1,   0, 16383,   "min_sq"};
        vecs[7] = '{0,    0,   0,    0,   7,     0, 7,       "k0_bias"};
        vecs[8] = '{1,    127, 0,    127, 32767, 0, 48896,   "max_bias"};

        // asynchronous reset before any clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("reset outputs", 32'({z_valid, in_ready, busy}), 0);
        chk("reset z_out", 32'(|z_out_packed), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) do_pass(vecs[i]);

        // K=0 with a single negative bias lane
        bm100 = 16'hFF9C;
        bias_packed = '0;
        bias_packed[5*BIAS_W +: BIAS_W] = bm100;
        num_inputs = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("k0 z_valid", 32'(z_valid), 1);
        chk("k0 lane5 bits", 32'(z_out_packed[5*ACC_W +: ACC_W]), 32'h000FFF9C);
        chk("k0 lane0", lane_val(0), 0);
        chk("k0 lane6", lane_val(6), 0);
        z_ready = 1'b1;
        tick();
        z_ready = 1'b0;

        // DONE held with z_ready low while start pulses
        bias_packed = '0;
        num_inputs = 10'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        x_in = 8'd3;
        w_in_packed = {N_NEURONS{8'd2}};
        tick();
        tick();
        in_valid = 1'b0;
        held = z_out_packed;
        chk_lanes("hold result", 12);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            start = (i % 2 == 0);
            num_inputs = 10'd5;
            in_valid = 1'b1;
            tick();
            if (z_valid !== 1'b1 || z_out_packed !== held || in_ready !== 1'b0) bad++;
        end
        in_valid = 1'b0;
        chk("hold stable cycles_bad", bad, 0);
        start = 1'b1;
        z_ready = 1'b1;
        tick();
        start = 1'b0;
        z_ready = 1'b0;
        chk("start+z_ready to idle", 32'({z_valid, busy}), 0);
        tick();
        chk("start in done ignored", 32'(busy), 0);

        // in_valid and z_ready while idle have no effect
        in_valid = 1'b1;
        z_ready = 1'b1;
        x_in = 8'd5;
        tick();
        tick();
        tick();
        in_valid = 1'b0;
        z_ready = 1'b0;
        chk("idle ignores inputs busy", 32'({busy, z_valid}), 0);
        chk_lanes("idle acc unchanged", 12);

        // reset after 2 of 5 beats
        bias_packed = {N_NEURONS{16'd3}};
        num_inputs = 10'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        x_in = 8'd10;
        w_in_packed = {N_NEURONS{8'd1}};
        tick();
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid reset z_out", 32'(|z_out_packed), 0);
        chk("mid reset flags", 32'({z_valid, in_ready, busy}), 0);
        tick();
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (z_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        chk("no z_valid after reset", bad, 0);
        r = '{5, 1, 1, 1, 0, 0, 15, "after_reset"};
        do_pass(r);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/layer_accumulator.md
LAYER_ACCUMULATOR -- requirements
Module: layer_accumulator

Interface
REQ-001 Parameter N_NEURONS, 32, number of parallel neuron accumulators.
REQ-002 Parameter DATA_W, 8, signed activation/weight width.
REQ-003 Parameter ACC_W, 20, signed accumulator / pre-activation width.
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port rst_n  input  1  asynchronous active-low reset.
REQ-006 Port start  input  1  begin new layer pass; sampled only in IDLE.
REQ-007 Port num_inputs  input  10  input vector length K (0..1023); latched on accepted start.
REQ-008 Port bias_packed  input  512  32 x 16-bit signed biases, lane j at [j*16 +: 16]; latched on accepted start.
REQ-009 Port in_valid  input  1  x_in/w_in_packed carry a valid beat.
REQ-010 Port in_ready  output  1  block accepts a beat this cycle.
REQ-011 Port x_in  input  8  signed input activation for current beat.
REQ-012 Port w_in_packed  input  256  32 x int8 weights for current beat, lane j at [j*8 +: 8].
REQ-013 Port z_out_packed  output  640  32 x 20-bit signed pre-activations, lane j at [j*20 +: 20].
REQ-014 Port z_valid  output  1  z_out_packed holds a completed result.
REQ-015 Port z_ready  input  1  downstream (ReLU stage) consumes result.
REQ-016 Port busy  output  1  high in any state other than IDLE.

Function
REQ-017 FSM states SHALL be IDLE, ACCUM, DONE.
REQ-018 IDLE: in_ready=0, z_valid=0; start=1 with num_inputs!=0 -> ACCUM; start=1 with num_inputs=0 -> DONE.
REQ-019 On accepted start each acc[j] SHALL load sign-extended bias lane j (16->20), beat counter cleared to 0.
REQ-020 ACCUM: in_ready=1; a beat transfers when in_valid & in_ready; no transfer leaves state unchanged.
REQ-021 Per transferred beat, acc[j] SHALL become sat20(acc[j] + x_in*w[j]), product 16-bit signed, sum computed at 21 bits.
REQ-022 sat20: clamp to +524287 (20'h7FFFF) or -524288 (20'h80000); saturation is sticky only by arithmetic, not flagged.
REQ-023 Counter SHALL increment per beat; beat with counter == K-1 is last -> DONE next cycle.
REQ-024 DONE: in_ready=0, z_valid=1, z_out_packed=acc, held stable until z_ready=1.
REQ-025 z_valid & z_ready -> IDLE next cycle; z_valid low from that cycle.
REQ-026 Latency: z_valid SHALL assert the cycle after the last beat's rising edge (one-cycle).
REQ-027 start outside IDLE SHALL be ignored; in_valid outside ACCUM SHALL be ignored.
REQ-028 z_ready while z_valid=0 SHALL have no effect.
REQ-029 start and z_ready in same DONE cycle: return to IDLE only; new start needs IDLE.
REQ-030 busy SHALL equal (state != IDLE), registered with state.

Reset
REQ-031 rst_n low SHALL asynchronously force IDLE, counter=0, all acc=0, z_out_packed=0, z_valid=0, in_ready=0, busy=0.
REQ-032 Reset mid-ACCUM or mid-DONE SHALL discard partial result; no z_valid pulse follows.
REQ-033 Reset deassertion SHALL be used synchronously-released by top-level synchronizer; block needs no internal one.

Structure
REQ-034 Shared package SHALL hold N_NEURONS, DATA_W, ACC_W, ACC_MAX/ACC_MIN constants and FSM state encoding, shared with ReLU stage.
REQ-035 One sub-module mac_lane (single-lane multiply, add, saturate) SHALL be instantiated N_NEURONS times via generate.
REQ-036 Packed-bus lane ordering SHALL match the ReLU stage z_in_packed exactly (lane j at bits j*20).

Verification
REQ-037 K=3, biases 0, x={1,2,3}, all w=1 -> each lane z=6, z_valid one cycle after beat 3.
REQ-038 K=0, bias lane5=-100, others 0 -> DONE directly, lane5 z=-100 (20'hFFF9C), others 0.
REQ-039 K=40, x=127, w=127, bias 0 -> lane z=+524287 (saturated); w=-128 -> -524288.
REQ-040 in_valid toggled 1/0 per cycle, K=4 -> result identical to back-to-back case; in_ready high throughout ACCUM.
REQ-041 z_ready held low 10 cycles in DONE -> z_out_packed stable, start pulses ignored; z_ready=1 -> IDLE.
REQ-042 rst_n low after 2 of 5 beats -> all outputs 0 immediately; fresh start yields correct full result.
